// File: rtl/text_char_buffer_if.sv
// CPU write / clear and LCD read bundle for the character-cell text buffer.
interface text_char_buffer_if;
  logic       wr_valid;
  logic       wr_ready;
  logic [5:0] wr_col;
  logic [4:0] wr_row;
  logic [7:0] wr_data;
  logic       clr_req;
  logic       busy;
  logic       rd_en;
  logic [5:0] rd_col;
  logic [4:0] rd_row;
  logic [7:0] Character;
  logic       char_valid;

  modport master (
    output wr_valid, wr_col, wr_row, wr_data, clr_req, rd_en, rd_col, rd_row,
    input  wr_ready, busy, Character, char_valid
  );

  modport slave (
    input  wr_valid, wr_col, wr_row, wr_data, clr_req, rd_en, rd_col, rd_row,
    output wr_ready, busy, Character, char_valid
  );
endinterface

// File: rtl/text_char_buffer.sv
// Character-cell text RAM feeding the LCD glyph stage, with a clear-screen FSM.
// state   | meaning
// S_CLEAR | sweeping every cell with CLEAR_CHAR, writes blocked
// S_IDLE  | CPU writes accepted, clr_req starts a new sweep
module text_char_buffer #(
  parameter int         COLS       = 60,
  parameter int         ROWS       = 17,
  parameter logic [7:0] CLEAR_CHAR = 8'h20,
  parameter int         AW         = $clog2(COLS * ROWS)
) (
  input logic               PixelClk,
  input logic               nRST,
  text_char_buffer_if.slave bus
);
  localparam int            CELLS     = COLS * ROWS;
  localparam logic [AW-1:0] LAST_ADDR = AW'(CELLS - 1);
  localparam logic [AW-1:0] COLS_A    = AW'(COLS);
  localparam logic [5:0]    COLS_C    = 6'(COLS);
  localparam logic [4:0]    ROWS_R    = 5'(ROWS);

  typedef enum logic {S_CLEAR, S_IDLE} state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] clr_addr, clr_addr_nxt;
  logic          clearing;

  logic          wr_in_range, rd_in_range;
  logic [AW-1:0] wr_addr, rd_addr;
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [7:0]    mem_wdata;

  logic [7:0]    mem [CELLS];
  logic [7:0]    ram_q;
  logic          rd_en_q;
  logic          rd_blank_q;

  function automatic logic [AW-1:0] cell_addr(input logic [4:0] row, input logic [5:0] col);
    return AW'(row) * COLS_A + AW'(col);
  endfunction

  assign wr_in_range = (bus.wr_col < COLS_C) && (bus.wr_row < ROWS_R);
  assign rd_in_range = (bus.rd_col < COLS_C) && (bus.rd_row < ROWS_R);
  assign wr_addr     = cell_addr(bus.wr_row, bus.wr_col);
  // Out-of-range reads are blanked later; park the address to stay inside the array.
  assign rd_addr     = rd_in_range ? cell_addr(bus.rd_row, bus.rd_col) : '0;

  assign clearing     = (state == S_CLEAR);
  assign bus.busy     = clearing;
  assign bus.wr_ready = !clearing;

  always_comb begin
    state_nxt    = state;
    clr_addr_nxt = clr_addr;
    mem_we       = 1'b0;
    mem_waddr    = wr_addr;
    mem_wdata    = bus.wr_data;
    case (state)
      S_CLEAR: begin
        mem_we       = 1'b1;
        mem_waddr    = clr_addr;
        mem_wdata    = CLEAR_CHAR;
        clr_addr_nxt = clr_addr + 1'b1;
        if (clr_addr == LAST_ADDR) begin
          state_nxt    = S_IDLE;
          clr_addr_nxt = '0;
        end
      end
      S_IDLE: begin
        mem_we = bus.wr_valid && wr_in_range;
        if (bus.clr_req) begin
          state_nxt    = S_CLEAR;
          clr_addr_nxt = '0;
        end
      end
      default: state_nxt = S_CLEAR;
    endcase
  end

  // Block RAM: read and write on the same edge, so a colliding read sees the old code.
  always_ff @(posedge PixelClk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
    if (bus.rd_en) ram_q <= mem[rd_addr];
  end

  always_ff @(posedge PixelClk or negedge nRST) begin
    if (!nRST) begin
      state          <= S_CLEAR;
      clr_addr       <= '0;
      rd_en_q        <= 1'b0;
      rd_blank_q     <= 1'b0;
      bus.Character  <= 8'h00;
      bus.char_valid <= 1'b0;
    end else begin
      state          <= state_nxt;
      clr_addr       <= clr_addr_nxt;
      rd_en_q        <= bus.rd_en;
      bus.char_valid <= rd_en_q;
      if (bus.rd_en) rd_blank_q <= !rd_in_range || clearing;
      if (rd_en_q) bus.Character <= rd_blank_q ? CLEAR_CHAR : ram_q;
    end
  end
endmodule

// File: tb/tb_text_char_buffer.sv
// Randomized scoreboard bench for text_char_buffer against an array/countdown model.
module tb_text_char_buffer;
  localparam int         COLS  = 60;
  localparam int         ROWS  = 17;
  localparam int         CELLS = COLS * ROWS;
  localparam logic [7:0] CLR   = 8'h20;

  typedef struct {
    logic [7:0] data;
    int         stamp;
  } exp_t;

  logic clk;
  logic nRST;
  int   cyc;
  int   compared;
  int   mismatched;
  int   clear_left;
  logic [7:0] model_mem [CELLS];
  exp_t q [$];

  text_char_buffer_if bus ();

  text_char_buffer dut (
    .PixelClk(clk),
    .nRST    (nRST),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference behaviour of one clock cycle, given the inputs currently driven.
  task automatic cycle_model();
    bit   busy_now;
    bit   rd_ok;
    bit   wr_ok;
    exp_t e;
    busy_now = (clear_left > 0);
    check("busy", bus.busy, busy_now);
    check("wr_ready", bus.wr_ready, !busy_now);
    rd_ok = (int'(bus.rd_col) < COLS) && (int'(bus.rd_row) < ROWS);
    if (bus.rd_en) begin
      e.stamp = cyc;
      e.data  = (!rd_ok || busy_now) ? CLR : model_mem[int'(bus.rd_row) * COLS + int'(bus.rd_col)];
      q.push_back(e);
    end
    if (busy_now) begin
      clear_left--;
    end else begin
      wr_ok = (int'(bus.wr_col) < COLS) && (int'(bus.wr_row) < ROWS);
      if (bus.wr_valid && wr_ok)
        model_mem[int'(bus.wr_row) * COLS + int'(bus.wr_col)] = bus.wr_data;
      if (bus.clr_req) begin
        clear_left = CELLS;
        foreach (model_mem[i]) model_mem[i] = CLR;
      end
    end
  endtask

  task automatic set_inputs(input bit wv, input int wc, input int wr, input logic [7:0] wd,
                            input bit clr, input bit re, input int rc, input int rr);
    bus.wr_valid = wv;
    bus.wr_col   = 6'(wc);
    bus.wr_row   = 5'(wr);
    bus.wr_data  = wd;
    bus.clr_req  = clr;
    bus.rd_en    = re;
    bus.rd_col   = 6'(rc);
    bus.rd_row   = 5'(rr);
  endtask

  task automatic drive(input bit wv, input int wc, input int wr, input logic [7:0] wd,
                       input bit clr, input bit re, input int rc, input int rr);
    @(negedge clk);
    set_inputs(wv, wc, wr, wd, clr, re, rc, rr);
    cycle_model();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 8'h00, 0, 0, 0, 0);
  endtask

  task automatic rand_read_cycle(input bit clr);
    drive(0, 0, 0, 8'h00, clr, $urandom_range(0, 1) == 1,
          $urandom_range(0, 61), $urandom_range(0, 17));
  endtask

  // The release cycle is itself the first clear cycle.
  task automatic release_reset();
    @(negedge clk);
    nRST = 1'b1;
    set_inputs(0, 0, 0, 8'h00, 0, 0, 0, 0);
    clear_left = CELLS;
    foreach (model_mem[i]) model_mem[i] = CLR;
    cycle_model();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_Character"}, bus.Character, 8'h00);
    check({tag, "_char_valid"}, bus.char_valid, 1'b0);
    check({tag, "_busy"}, bus.busy, 1'b1);
    check({tag, "_wr_ready"}, bus.wr_ready, 1'b0);
  endtask

  // Monitor: pops the expected response when its 2-cycle slot arrives.
  always @(negedge clk) begin
    if (nRST === 1'b1) begin
      if (q.size() > 0 && q[0].stamp + 2 == cyc) begin
        exp_t e;
        e = q.pop_front();
        check("char_valid", bus.char_valid, 1'b1);
        check("Character", bus.Character, e.data);
      end else begin
        check("char_valid_idle", bus.char_valid, 1'b0);
      end
    end
  end

  initial begin
    cyc        = 0;
    compared   = 0;
    mismatched = 0;
    clear_left = 0;
    nRST       = 1'b1;
    set_inputs(0, 0, 0, 8'h00, 0, 0, 0, 0);
    #3 nRST = 1'b0;
    #1 check_reset_outputs("reset");
    repeat (3) @(negedge clk);
    check_reset_outputs("reset_hold");

    // Post-reset clear with reads arriving during it.
    release_reset();
    for (int i = 0; i < CELLS + 4; i++) rand_read_cycle(0);

    // Every cell reads back as blank, back-to-back.
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) drive(0, 0, 0, 8'h00, 0, 1, c, r);
    idle(3);

    // Single write and its neighbour.
    drive(1, 5, 3, 8'h41, 0, 0, 0, 0);
    drive(0, 0, 0, 8'h00, 0, 1, 5, 3);
    drive(0, 0, 0, 8'h00, 0, 1, 6, 3);
    idle(3);

    // Last cell plus out-of-range writes.
    drive(1, 59, 16, 8'h7E, 0, 0, 0, 0);
    drive(1, 60, 0, 8'h55, 0, 0, 0, 0);
    drive(1, 0, 17, 8'h55, 0, 0, 0, 0);
    drive(0, 0, 0, 8'h00, 0, 1, 59, 16);
    drive(0, 0, 0, 8'h00, 0, 1, 60, 0);
    drive(0, 0, 0, 8'h00, 0, 1, 0, 17);
    drive(0, 0, 0, 8'h00, 0, 1, 0, 0);
    idle(3);

    // Fill, then clear coincident with a write, with a stray clr_req mid-clear.
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) drive(1, c, r, 8'h30, 0, 0, 0, 0);
    drive(0, 0, 0, 8'h00, 0, 1, 7, 7);
    drive(1, 0, 0, 8'h31, 1, 0, 0, 0);
    for (int i = 0; i < CELLS + 4; i++) rand_read_cycle(i == 500);
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) drive(0, 0, 0, 8'h00, 0, 1, c, r);
    idle(3);

    // Continuous row reads colliding with writes to the same cell.
    for (int c = 0; c < COLS; c++) begin
      drive(1, c, 2, 8'($urandom_range(0, 255)), 0, 1, c, 2);
      drive(0, 0, 0, 8'h00, 0, 1, c, 2);
    end
    idle(3);

    // Random mixed traffic, including occasional clears and out-of-range cells.
    for (int i = 0; i < 2000; i++)
      drive($urandom_range(0, 1) == 1, $urandom_range(0, 62), $urandom_range(0, 18),
            8'($urandom_range(0, 255)), $urandom_range(0, 299) == 0,
            $urandom_range(0, 3) != 0, $urandom_range(0, 62), $urandom_range(0, 18));
    idle(3);

    // Reset mid-clear, with reads in flight.
    drive(0, 0, 0, 8'h00, 0, 1, 5, 3);
    drive(0, 0, 0, 8'h00, 1, 1, 5, 3);
    for (int i = 1; i < 400; i++) rand_read_cycle(0);
    @(negedge clk);
    set_inputs(0, 0, 0, 8'h00, 0, 1, 1, 1);
    #2 nRST = 1'b0;
    #1 check_reset_outputs("midclear_reset");
    q.delete();
    set_inputs(0, 0, 0, 8'h00, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    release_reset();
    for (int i = 0; i < CELLS + 4; i++) rand_read_cycle(0);
    drive(0, 0, 0, 8'h00, 0, 1, 5, 3);
    idle(4);

    check("queue_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/text_char_buffer.md
Name: text_char_buffer

Overview:
- Character-cell text RAM that directly feeds the `Character` input of the `lcd` pixel/glyph stage.
- The CPU side writes character codes into a COLS x ROWS grid. The LCD side presents a cell position and receives that cell's code with fixed latency.
- Includes a clear-screen FSM, run automatically after reset and on request. Storage maps to one simple dual-port BSRAM.

Parameters:
- COLS, 60, text columns (480 px / 8 px glyph)
- ROWS, 17, text rows (272 px / 16 px glyph)
- CLEAR_CHAR, 8'h20, code written by clear; also returned for out-of-range/blanked reads
- AW, $clog2(COLS*ROWS) (=10), cell address width

Ports:
- PixelClk  in   1   sole clock
- nRST      in   1   asynchronous active-low reset
- wr_valid  in   1   CPU write request
- wr_ready  out  1   write accepted when wr_valid && wr_ready
- wr_col    in   6   write column
- wr_row    in   5   write row
- wr_data   in   8   character code to store
- clr_req   in   1   clear-screen request, sampled in IDLE only
- busy      out  1   high while clearing
- rd_en     in   1   read request from LCD timing
- rd_col    in   6   read column
- rd_row    in   5   read row
- Character out  8   code for requested cell, to lcd.Character
- char_valid out 1   Character corresponds to a request issued 2 cycles earlier

Behaviour:
- Address = row*COLS + col, computed in AW bits; no multiplier inference required (shift-add allowed).

FSM states:
- CLEAR: on nRST deassert, clr_addr=0, busy=1, wr_ready=0.
  - Each cycle writes CLEAR_CHAR to clr_addr, then increments it.
  - After writing address COLS*ROWS-1, go to IDLE. Clear takes exactly COLS*ROWS cycles (1020 at defaults).
- IDLE: busy=0, wr_ready=1.
  - Write: wr_valid=1 stores wr_data at the addressed cell that cycle.
  - Clear request: clr_req=1 goes to CLEAR next cycle (clr_addr=0).

Write and request rules:
- wr_valid && clr_req in the same IDLE cycle: the write is performed, then the clear runs and overwrites it.
- clr_req during CLEAR is ignored; the clear does not restart.
- Out-of-range write (wr_col>=COLS or wr_row>=ROWS): handshake completes, memory unchanged.

Read pipeline (latency 2):
- Cycle 0: rd_col/rd_row/rd_en sampled and address registered, along with an out-of-range flag and a busy snapshot.
- Cycle 1: BSRAM read.
- Cycle 2: Character registered. Character = CLEAR_CHAR if the request was out of range or busy was 1 at sample time; otherwise it is the RAM data.
- char_valid = rd_en delayed 2 cycles. Character holds its last value when rd_en=0.
- Back-to-back reads are accepted every cycle (full throughput).
- Read and write to the same address in the same cycle: read returns the old data (read-first).

Reset:
- Async assert: Character=8'h00, char_valid=0, busy=1, wr_ready=0, pipeline flags cleared, clr_addr=0, state=CLEAR.
- Reset mid-clear or mid-read aborts both; the clear restarts from address 0 after release.
- RAM contents are not reset; the post-reset clear defines them.

Test Plan:
- Release nRST -> busy=1 and wr_ready=0 for exactly 1020 cycles, then busy=0 and wr_ready=1. Reading every cell afterwards returns 8'h20 with char_valid 2 cycles after each rd_en.
- Write 8'h41 to (col 5, row 3), then read (5,3) -> Character=8'h41 two cycles after rd_en. Neighbour (6,3) reads 8'h20.
- Write (59,16)=8'h7E, then write (60,0)=8'h55 and (0,17)=8'h55 -> the first is stored. The two out-of-range writes are acknowledged without changing memory, and reading (60,0) returns 8'h20.
- Fill cells with 8'h30, then pulse clr_req together with a write of 8'h31 to (0,0) -> busy for 1020 cycles. Afterwards (0,0) and all other cells read 8'h20. A clr_req pulsed mid-clear does not extend the clear.
- Continuous reads across a row while writing the same cell -> the read in the collision cycle returns the old code, and the next read returns the new code. No bubbles in char_valid.
- Assert nRST at cycle 400 of a clear -> outputs take their reset values immediately. After release, the clear runs a full 1020 cycles again.
